// File: rtl/motor_cmd_scheduler.sv
// Frame scheduler between motor mixing and the four ESC stages: saturates the
// requested speeds, slew-limits them once per frame and issues the write strobe.
module motor_cmd_scheduler #(
    parameter int FRAME_TICKS  = 125000,
    parameter int SLEW_STEP    = 64,
    parameter int STALE_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vld,
    input  logic        arm,
    input  logic [11:0] frnt_req,
    input  logic [11:0] bck_req,
    input  logic [11:0] lft_req,
    input  logic [11:0] rght_req,
    output logic        cmd_ack,
    output logic [10:0] frnt_spd,
    output logic [10:0] bck_spd,
    output logic [10:0] lft_spd,
    output logic [10:0] rght_spd,
    output logic        wrt,
    output logic        stale
);

    localparam int              CW        = $clog2(FRAME_TICKS);
    localparam logic [CW-1:0]   LAST      = CW'(FRAME_TICKS - 1);
    localparam logic [11:0]     STEP      = 12'(SLEW_STEP);
    localparam logic [7:0]      STALE_LIM = 8'(STALE_FRAMES);

    logic [CW-1:0] r_cnt;
    logic [10:0]   r_tgt [4];
    logic [10:0]   r_spd [4];
    logic [7:0]    r_staleCnt;
    logic          r_stale;
    logic          r_wrt;
    logic          r_ack;

    logic          w_tick;
    logic [11:0]   w_req  [4];
    logic [10:0]   w_sat  [4];
    logic [10:0]   w_eff  [4];
    logic [10:0]   w_slew [4];

    assign w_req[0] = frnt_req;
    assign w_req[1] = bck_req;
    assign w_req[2] = lft_req;
    assign w_req[3] = rght_req;

    assign w_tick = (r_cnt == LAST);

    // Saturate requests to the ESC range and compute each motor's next slew-limited speed.
    // A disarmed motor is forced to zero in the register process, so only stale gates the target here.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_sat[i]  = (w_req[i] > 12'd2047) ? 11'h7FF : w_req[i][10:0];
            w_eff[i]  = r_stale ? 11'd0 : r_tgt[i];
            w_slew[i] = r_spd[i];
            if (w_eff[i] > r_spd[i]) begin
                w_slew[i] = (({1'b0, w_eff[i]} - {1'b0, r_spd[i]}) > STEP)
                            ? r_spd[i] + STEP[10:0] : w_eff[i];
            end else if (w_eff[i] < r_spd[i]) begin
                w_slew[i] = (({1'b0, r_spd[i]} - {1'b0, w_eff[i]}) > STEP)
                            ? r_spd[i] - STEP[10:0] : w_eff[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_wrt <= 1'b0;
            r_ack <= 1'b0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
            r_wrt <= w_tick;
            r_ack <= vld;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_tgt[i] <= '0;
                r_spd[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (vld)
                    r_tgt[i] <= w_sat[i];
                if (!arm)
                    r_spd[i] <= '0;
                else if (w_tick)
                    r_spd[i] <= w_slew[i];
            end
        end
    end

    // A fresh command always wins over the frame-based stale count on a coincident edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_staleCnt <= '0;
            r_stale    <= 1'b0;
        end else if (vld) begin
            r_staleCnt <= '0;
            r_stale    <= 1'b0;
        end else if (w_tick && (r_staleCnt < STALE_LIM)) begin
            r_staleCnt <= r_staleCnt + 8'd1;
            if (r_staleCnt == STALE_LIM - 8'd1)
                r_stale <= 1'b1;
        end
    end

    assign cmd_ack  = r_ack;
    assign wrt      = r_wrt;
    assign stale    = r_stale;
    assign frnt_spd = r_spd[0];
    assign bck_spd  = r_spd[1];
    assign lft_spd  = r_spd[2];
    assign rght_spd = r_spd[3];

endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// Scoreboard bench for motor_cmd_scheduler: a frame-level reference model queues
// expected strobes/acks and tracks expected speeds; a monitor checks every cycle.
module tb_motor_cmd_scheduler;

    localparam int F     = 100;
    localparam int STEP  = 64;
    localparam int STALE = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld = 1'b0;
    logic        arm = 1'b1;
    logic [11:0] frnt_req = '0, bck_req = '0, lft_req = '0, rght_req = '0;
    logic        cmd_ack, wrt, stale;
    logic [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;

    int nCompared = 0;
    int nFail     = 0;

    int edgeN = 0;
    int mTgt [4];
    int mSpd [4];
    int mStaleCnt = 0;
    bit mStale = 1'b0;
    int frameQ [$];
    int ackQ   [$];

    int cf = 0, cb = 0, cl = 0, cr = 0;

    motor_cmd_scheduler #(
        .FRAME_TICKS (F),
        .SLEW_STEP   (STEP),
        .STALE_FRAMES(STALE)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .vld     (vld),
        .arm     (arm),
        .frnt_req(frnt_req),
        .bck_req (bck_req),
        .lft_req (lft_req),
        .rght_req(rght_req),
        .cmd_ack (cmd_ack),
        .frnt_spd(frnt_spd),
        .bck_spd (bck_spd),
        .lft_spd (lft_spd),
        .rght_spd(rght_spd),
        .wrt     (wrt),
        .stale   (stale)
    );

    always #5 clk = ~clk;

    function automatic int moveToward(input int s, input int t);
        int d;
        d = (t > s) ? t - s : s - t;
        if (d > STEP) d = STEP;
        return (t > s) ? s + d : s - d;
    endfunction

    function automatic logic [43:0] packSpd(input int a, input int b, input int c, input int d);
        return {11'(a), 11'(b), 11'(c), 11'(d)};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s at edge %0d: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, edgeN, act, act, exp, exp);
        end
    endtask

    // Reference model: frame-level rules evaluated once per rising edge.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                edgeN = 0;
                for (int i = 0; i < 4; i++) begin
                    mTgt[i] = 0;
                    mSpd[i] = 0;
                end
                mStale = 1'b0;
                mStaleCnt = 0;
                frameQ.delete();
                ackQ.delete();
            end else begin
                int reqs [4];
                bit isTick;
                edgeN++;
                isTick = (edgeN % F) == 0;
                reqs = '{int'(frnt_req), int'(bck_req), int'(lft_req), int'(rght_req)};
                for (int i = 0; i < 4; i++) begin
                    if (!arm)
                        mSpd[i] = 0;
                    else if (isTick)
                        mSpd[i] = moveToward(mSpd[i], mStale ? 0 : mTgt[i]);
                end
                if (vld) begin
                    for (int i = 0; i < 4; i++)
                        mTgt[i] = (reqs[i] > 2047) ? 2047 : reqs[i];
                    mStaleCnt = 0;
                    mStale = 1'b0;
                    ackQ.push_back(edgeN);
                end else if (isTick) begin
                    if (mStaleCnt < STALE) mStaleCnt++;
                    if (mStaleCnt == STALE) mStale = 1'b1;
                end
                if (isTick) frameQ.push_back(edgeN);
            end
        end
    end

    // Monitor: sample away from the active edge and pop expected events when due.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                bit expWrt, expAck;
                expWrt = (frameQ.size() > 0) && (frameQ[0] == edgeN);
                expAck = (ackQ.size() > 0) && (ackQ[0] == edgeN);
                checkOutput("wrt", 64'(wrt), 64'(expWrt));
                checkOutput("cmd_ack", 64'(cmd_ack), 64'(expAck));
                if (expWrt) void'(frameQ.pop_front());
                if (expAck) void'(ackQ.pop_front());
                checkOutput("speeds", 64'({frnt_spd, bck_spd, lft_spd, rght_spd}),
                            64'(packSpd(mSpd[0], mSpd[1], mSpd[2], mSpd[3])));
                checkOutput("stale", 64'(stale), 64'(mStale));
            end
        end
    end

    task automatic applyStimulus(input int f, input int b, input int l, input int r);
        frnt_req = 12'(f);
        bck_req  = 12'(b);
        lft_req  = 12'(l);
        rght_req = 12'(r);
        vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
    endtask

    // Re-send the current command once per frame so the failsafe stays idle.
    task automatic refresh(input int frames);
        for (int k = 0; k < frames; k++) begin
            repeat (F / 2) @(negedge clk);
            applyStimulus(cf, cb, cl, cr);
            repeat (F / 2 - 1) @(negedge clk);
        end
    endtask

    task automatic alignToTick();
        int guard = 0;
        while (((edgeN + 1) % F) != 0 && guard < 2 * F) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("align_timeout", 64'(guard >= 2 * F), 64'(0));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs",
                    64'({cmd_ack, wrt, stale, frnt_spd, bck_spd, lft_spd, rght_spd}), 64'(0));
        rst_n = 1'b1;

        repeat (3 * F + 5) @(negedge clk);

        cf = 4000; cb = 100; cl = 2047; cr = 2048;
        refresh(34);

        cf = 1000; cb = 0; cl = 64; cr = 1;
        refresh(20);

        cf = 1500; cb = 700; cl = 3000; cr = 300;
        refresh(12);
        repeat (F / 3) @(negedge clk);
        arm = 1'b0;
        refresh(2);
        arm = 1'b1;
        refresh(6);

        cf = 0; cb = 0; cl = 0; cr = 0;
        refresh(34);
        alignToTick();
        cf = 1200; cb = 1200; cl = 1200; cr = 1200;
        applyStimulus(cf, cb, cl, cr);
        refresh(3);

        cf = 500; cb = 500; cl = 500; cr = 500;
        refresh(12);
        repeat (12 * F) @(negedge clk);
        refresh(8);

        for (int c = 0; c < 60 * F; c++) begin
            if ($urandom_range(0, 299) == 0) arm = ~arm;
            if ($urandom_range(0, 39) == 0) begin
                cf = $urandom_range(0, 4095); cb = $urandom_range(0, 4095);
                cl = $urandom_range(0, 4095); cr = $urandom_range(0, 4095);
                applyStimulus(cf, cb, cl, cr);
                if ($urandom_range(0, 3) == 0) applyStimulus(cf / 2, cb, cl / 3, cr);
            end else begin
                @(negedge clk);
            end
        end
        arm = 1'b1;
        refresh(4);

        repeat (F / 2 + 17) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midframe_reset",
                    64'({cmd_ack, wrt, stale, frnt_spd, bck_spd, lft_spd, rght_spd}), 64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        refresh(4);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
        $finish;
    end

endmodule
